axi4_lite_write_dpm: RTL and testbench

AXI4-lite write responder backed by a byte-enable block RAM, with a local read port on the same clock. It accepts AW and W independently, joins them, commits one word with per-byte strobes, and returns a B response. It is the write-direction counterpart of the read-only memory slave: firmware writes over AXI4-lite and local logic reads the RAM. One write is outstanding at a time.

---
 rtl/axi4_lite_write_dpm_pkg.sv | 12 +
 rtl/axi4_lite_write_dpm_ram.sv | 47 ++++
 rtl/axi4_lite_write_dpm.sv | 135 +++++++++++++
 tb/tb_axi4_lite_write_dpm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_write_dpm_pkg.sv
// Shared types and constants for the AXI4-lite write responder backed by a byte-enable RAM.
package axi4_lite_write_dpm_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMMIT  = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi4_lite_write_dpm_ram.sv
// Single-clock byte-enable RAM with a registered read port.
// Optional write-to-read bypass when AXI4_LITE_WRITE_DPM_FWD_EN is defined.
module axi4_lite_write_dpm_ram #(
    parameter int W  = 32,
    parameter int AW = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [W-1:0]      wdata,
    input  logic [W/8-1:0]    wstrb,
    input  logic [AW-1:0]     raddr,
    output logic [W-1:0]      rdata
);
    import axi4_lite_write_dpm_pkg::*;

    localparam int NB = W / 8;

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rd_next;

    always_comb begin
        rd_next = mem[raddr];
`ifdef AXI4_LITE_WRITE_DPM_FWD_EN
        // Same-word read during a write sees the merged word: new strobed bytes, old others.
        if (we && (raddr == waddr)) begin
            for (int k = 0; k < NB; k++) begin
                if (wstrb[k]) begin
                    rd_next[k*8 +: 8] = wdata[k*8 +: 8];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NB; k++) begin
                if (wstrb[k]) begin
                    mem[waddr][k*8 +: 8] <= wdata[k*8 +: 8];
                end
            end
        end
        rdata <= rd_next;
    end

endmodule

// File: rtl/axi4_lite_write_dpm.sv
// AXI4-lite write responder: independent AW/W holding registers joined into one RAM commit
// and a B response; local read port on the same clock. Build option: AXI4_LITE_WRITE_DPM_FWD_EN.
module axi4_lite_write_dpm #(
    parameter int A  = 8,
    parameter int N  = 4,
    parameter int I  = 1,
    parameter int W  = N * 8,
    parameter int LB = (N == 8) ? 3 : 2
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            awvalid,
    output logic            awready,
    input  logic [A-1:0]    awaddr,
    input  logic [I-1:0]    awid,
    input  logic [2:0]      awprot,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            wvalid,
    output logic            wready,
    input  logic [W-1:0]    wdata,
    input  logic [N-1:0]    wstrb,
    input  logic            wlast,
    output logic            bvalid,
    input  logic            bready,
    output logic [1:0]      bresp,
    output logic [I-1:0]    bid,
    input  logic            arvalid,
    output logic            arready,
    input  logic [A-1:0]    araddr,
    input  logic [I-1:0]    arid,
    input  logic [2:0]      arprot,
    output logic            rvalid,
    input  logic            rready,
    output logic [W-1:0]    rdata,
    output logic [1:0]      rresp,
    output logic [I-1:0]    rid,
    output logic            rlast,
    input  logic [A-LB-1:0] b_addr,
    output logic [W-1:0]    b_dout
);
    import axi4_lite_write_dpm_pkg::*;

    localparam int AW = A - LB;

    state_t          state, state_next;
    logic            aw_full, w_full;
    logic [AW-1:0]   aw_word;
    logic [I-1:0]    aw_id;
    logic [W-1:0]    w_data;
    logic [N-1:0]    w_strb;
    logic [I-1:0]    bid_q;
    logic            commit;

    // Inputs that carry no meaning for a single-beat word write.
    logic unused;
    assign unused = ^{awaddr[LB-1:0], awprot, awlen, awsize, awburst, wlast,
                      arvalid, araddr, arid, arprot, rready};

    assign arready = 1'b0;
    assign rvalid  = 1'b0;
    assign rdata   = '0;
    assign rresp   = RESP_OKAY;
    assign rid     = '0;
    assign rlast   = 1'b1;

    assign awready = ~aw_full;
    assign wready  = ~w_full;
    assign bid     = bid_q;
    assign bresp   = RESP_OKAY;

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        bvalid     = 1'b0;
        case (state)
            COLLECT: if (aw_full && w_full) state_next = COMMIT;
            COMMIT: begin
                commit     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                bvalid = 1'b1;
                if (bready) state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= COLLECT;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_word <= '0;
            aw_id   <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bid_q   <= '0;
        end else begin
            state <= state_next;
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bid_q   <= aw_id;
            end else begin
                if (awvalid && awready) begin
                    aw_full <= 1'b1;
                    aw_word <= awaddr[A-1:LB];
                    aw_id   <= awid;
                end
                if (wvalid && wready) begin
                    w_full <= 1'b1;
                    w_data <= wdata;
                    w_strb <= wstrb;
                end
            end
        end
    end

    axi4_lite_write_dpm_ram #(
        .W  (W),
        .AW (AW)
    ) u_ram (
        .clk   (aclk),
        .we    (commit),
        .waddr (aw_word),
        .wdata (w_data),
        .wstrb (w_strb),
        .raddr (b_addr),
        .rdata (b_dout)
    );

endmodule

// File: tb/tb_axi4_lite_write_dpm.sv
// Self-checking bench for axi4_lite_write_dpm (A=8, N=4, I=1) with an edge-indexed write model.
module tb_axi4_lite_write_dpm;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        awvalid, awready;
    logic [7:0]  awaddr;
    logic [0:0]  awid;
    logic [2:0]  awprot;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [0:0]  bid;
    logic        arvalid, arready;
    logic [7:0]  araddr;
    logic [0:0]  arid;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [0:0]  rid;
    logic        rlast;
    logic [5:0]  b_addr;
    logic [31:0] b_dout;

    int errors = 0;
    int checks = 0;

    axi4_lite_write_dpm #(.A(8), .N(4), .I(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awprot(awprot), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
        .b_addr(b_addr), .b_dout(b_dout)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every event is indexed by the clock edge at which it happens.
    logic [31:0] mem_m [64];
    bit          mem_ok [64];
    bit          aw_p, w_p, sched, b_out, dout_ok;
    int          aw_e, w_e, c_edge, last_b, cyc;
    logic [5:0]  aw_word_m;
    logic        aw_id_m, b_id_m;
    logic [31:0] w_dat_m, w_st_m_word, dout_m;
    logic [3:0]  w_st_m;

    initial begin
        aw_p = 0; w_p = 0; sched = 0; b_out = 0; dout_ok = 0; b_id_m = 0;
        last_b = -10; cyc = 0; aw_e = 0; w_e = 0; c_edge = 0;
        for (int i = 0; i < 64; i++) mem_ok[i] = 0;
    end

    always @(negedge aclk) begin
        int  e;
        bit  aw_rdy, w_rdy;
        logic [5:0] rd;
        logic [31:0] old;
        bit old_ok;
        if (!aresetn) begin
            aw_p = 0; w_p = 0; sched = 0; b_out = 0; b_id_m = 0; last_b = -10;
        end
        chk("awready", awready, !aw_p);
        chk("wready", wready, !w_p);
        chk("bvalid", bvalid, b_out);
        chk("arready", arready, 0);
        chk("rvalid", rvalid, 0);
        if (b_out) begin
            chk("bid", bid, b_id_m);
            chk("bresp", bresp, 0);
        end
        if (dout_ok) chk("b_dout", b_dout, dout_m);

        e = cyc + 1;
        rd = b_addr;
        old = mem_m[rd];
        old_ok = mem_ok[rd];
        if (aresetn) begin
            aw_rdy = !aw_p;
            w_rdy  = !w_p;
            if (b_out && bready) begin
                b_out = 0;
                last_b = e;
            end
            if (sched && c_edge == e) begin
                for (int k = 0; k < 4; k++)
                    if (w_st_m[k]) mem_m[aw_word_m][k*8 +: 8] = w_dat_m[k*8 +: 8];
                if (w_st_m == 4'hF) mem_ok[aw_word_m] = 1;
                aw_p = 0; w_p = 0; sched = 0;
                b_out = 1; b_id_m = aw_id_m;
            end
            if (awvalid && aw_rdy) begin
                aw_p = 1; aw_e = e; aw_word_m = awaddr[7:2]; aw_id_m = awid[0];
            end
            if (wvalid && w_rdy) begin
                w_p = 1; w_e = e; w_dat_m = wdata; w_st_m = wstrb;
            end
            if (!sched && !b_out && aw_p && w_p) begin
                c_edge = aw_e;
                if (w_e > c_edge) c_edge = w_e;
                if (last_b > c_edge) c_edge = last_b;
                c_edge = c_edge + 2;
                sched = 1;
            end
        end
`ifdef AXI4_LITE_WRITE_DPM_FWD_EN
        dout_m = mem_m[rd];
        dout_ok = mem_ok[rd];
`else
        dout_m = old;
        dout_ok = old_ok;
`endif
        cyc = e;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_bv();
        int n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("bvalid_wait", bvalid, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic id, input logic [31:0] d, input logic [3:0] s);
        awvalid = 1; awaddr = a; awid = id;
        wvalid = 1; wdata = d; wstrb = s;
        tick();
        awvalid = 0; wvalid = 0;
        wait_bv();
        tick();
    endtask

    initial begin
        aresetn = 0;
        awvalid = 0; awaddr = 0; awid = 0; awprot = 0; awlen = 0; awsize = 3'd2; awburst = 2'd1;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 1;
        bready = 1; arvalid = 0; araddr = 0; arid = 0; arprot = 0; rready = 1; b_addr = 0;
        tick(); tick();
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_bvalid", bvalid, 0);
        aresetn = 1;
        tick();

        // Same-cycle AW/W, B two edges after the handshake.
        awvalid = 1; awaddr = 8'h10; awid = 0;
        wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        chk("t1_bv_k", bvalid, 0);
        tick();
        chk("t1_bv_k1", bvalid, 0);
        tick();
        chk("t1_bv_k2", bvalid, 1);
        chk("t1_bresp", bresp, 0);
        tick();
        b_addr = 6'd4;
        tick();
        chk("t1_read", b_dout, 32'hDEADBEEF);

        // W first, AW five cycles later, partial strobe.
        wvalid = 1; wdata = 32'h11223344; wstrb = 4'h5;
        tick();
        wvalid = 0;
        repeat (4) tick();
        awvalid = 1; awaddr = 8'h10; awid = 1;
        tick();
        awvalid = 0;
        wait_bv();
        chk("t2_bid", bid, 1);
        tick(); tick();
        chk("t2_read", b_dout, 32'hDE22BE44);

        // Backpressure on B while the next write is accepted (AW before W).
        bready = 0;
        do_write(8'h20, 1'b0, 32'h01020304, 4'hF);
        awvalid = 1; awaddr = 8'h24; awid = 1;
        tick();
        awvalid = 0;
        chk("t3_hold_bv", bvalid, 1);
        chk("t3_hold_bid", bid, 0);
        tick();
        wvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        tick();
        wvalid = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t3_hold_bv", bvalid, 1);
            chk("t3_hold_bid", bid, 0);
        end
        bready = 1;
        tick();
        chk("t3_bv_h", bvalid, 0);
        tick();
        chk("t3_bv_h1", bvalid, 0);
        tick();
        chk("t3_bv_h2", bvalid, 1);
        chk("t3_bid2", bid, 1);
        tick();

        // Reset with both holding registers full discards the write.
        do_write(8'h30, 1'b0, 32'h0BADC0DE, 4'hF);
        awvalid = 1; awaddr = 8'h30; awid = 1;
        wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        aresetn = 0;
        #1;
        chk("t4_awready", awready, 1);
        chk("t4_wready", wready, 1);
        chk("t4_bvalid", bvalid, 0);
        tick(); tick();
        aresetn = 1;
        b_addr = 6'd12;
        repeat (4) tick();
        chk("t4_bvalid_after", bvalid, 0);
        chk("t4_ram_kept", b_dout, 32'h0BADC0DE);

        // Read of the word being committed.
        b_addr = 6'd4;
        awvalid = 1; awaddr = 8'h10; awid = 0;
        wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        tick(); tick();
        chk("t5_bv", bvalid, 1);
`ifdef AXI4_LITE_WRITE_DPM_FWD_EN
        chk("t5_rdw", b_dout, 32'hCAFEF00D);
`else
        chk("t5_rdw", b_dout, 32'hDE22BE44);
`endif
        tick();
        chk("t5_after", b_dout, 32'hCAFEF00D);

        // Read channels stay idle.
        arvalid = 1; araddr = 8'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_arready", arready, 0);
            chk("t6_rvalid", rvalid, 0);
        end
        arvalid = 0;
        b_addr = 6'd8;
        tick(); tick();
        chk("t6_word8", b_dout, 32'h01020304);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
